siaminer_resp_tx: RTL
=====================

# siaminer_resp_tx

Response-side UART transmitter for the siaminer host link. It accepts found-nonce and loop-test acknowledge events from the core and command parser, and frames each one as `0x55, cmd, len, payload`. Each frame is serialized as 8N1 on `ser_out` toward the host. It mirrors the host's `0xAA` request framing and sits between `uSiacore`/`uParser` and the board UART pin.

## Interface
- `CLKS_PER_BIT`, default 868, is the clock cycles per UART bit (100 MHz / 115200). Legal range is ≥ 2.
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `nonce_valid`  in  1  found-nonce request
- `nonce`  in  32  nonce value
- `nonce_ready`  out  1  nonce request slot free
- `loop_valid`  in  1  loop-ack request
- `loop_byte`  in  8  byte to echo
- `loop_ready`  out  1  loop request slot free
- `ser_out`  out  1  UART serial line, idle high
- `busy`  out  1  frame in transmission
- `new_tx_data`  out  1  one-cycle pulse when a byte's stop bit completes
- `tx_last_byte`  out  1  asserted with `new_tx_data` on the final byte of a frame

## Operation
- **Nonce frame:** `55 00 04 n[7:0] n[15:8] n[23:16] n[31:24]`, which is 7 bytes.
- **Loop frame:** `55 01 01 loop_byte`, which is 4 bytes.
- **Pending slots:** there are two single-entry slots, `nonce_pend` (holding the 32-bit value) and `loop_pend` (holding the 8-bit byte).
  - `nonce_ready` = !`nonce_pend` and `loop_ready` = !`loop_pend`.
  - A slot captures on valid & ready. If ready is low the source holds valid, and nothing is dropped.
- **Frame load:** in IDLE with any pending slot set, the FSM loads the frame, clears that slot, and enters START.
  - Nonce has priority over loop.
  - A slot frees at frame load, so a new request may be captured during transmission of the previous one.
- **FSM states:** IDLE, START, DATA, STOP.
  - START drives `ser_out` = 0 for CLKS_PER_BIT cycles.
  - DATA sends 8 bits LSB first, each for CLKS_PER_BIT cycles.
  - STOP drives `ser_out` = 1 for CLKS_PER_BIT cycles.
  - At the end of STOP: if bytes remain, go to START with the next byte and no idle gap. Otherwise go to IDLE.
- **Counters:**
  - Bit-time counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - Bit index runs 0..7.
  - Byte index runs 0..len+2; the frame ends when byte index = len+2 completes.
- **`busy`:** 1 from frame load until the last STOP completes. It is 0 in IDLE.
- **Simultaneous `nonce_valid` and `loop_valid` while both slots are free:** both are captured in the same cycle. The nonce frame goes first and the loop frame follows.
- **Reset mid-frame:** the frame is abandoned and pending slots are cleared. `ser_out` returns to 1 at the reset edge, with no partial byte completion.
- **Reset values:** `ser_out`=1, `busy`=0, `nonce_ready`=1, `loop_ready`=1, `new_tx_data`=0, `tx_last_byte`=0. State is IDLE and all counters are 0.

## Timing
- All outputs are registered.
- **Request to start bit:** the request is captured at edge N. At edge N+1 the frame loads, `ser_out` goes 0, and `busy` goes 1.
- **Readiness:** `nonce_ready`/`loop_ready` go low at edge N and return high at the load edge N+1 if that slot was the one loaded.
- **Byte duration:** 10·CLKS_PER_BIT cycles.
  - A nonce frame takes 70·CLKS_PER_BIT cycles.
  - A loop frame takes 40·CLKS_PER_BIT cycles.
- **`new_tx_data`:** high for exactly one cycle, at the cycle the stop bit's last clock ends. The next start bit, if any, begins the following cycle.
- **Back-to-back frames with a slot already pending:** the last stop ends and `busy`=0 for one cycle (IDLE). The next frame loads the following edge, so there is 1 idle-high cycle between frames.

## Test plan
- CLKS_PER_BIT=4; `nonce`=0x12345678 pulsed one cycle.
  - `ser_out` decodes `55 00 04 78 56 34 12`.
  - `busy` is high for 280 cycles.
  - 7 `new_tx_data` pulses; `tx_last_byte` is only on the 7th.
- `loop_byte`=0xA5. `ser_out` decodes `55 01 01 A5` and the frame takes 160 cycles.
- `nonce`=0xDEADBEEF and loop 0x3C asserted in the same cycle.
  - The nonce frame `55 00 04 EF BE AD DE` comes first.
  - One idle cycle follows, then `55 01 01 3C`.
  - Both readies return high.
- During nonce frame A, capture nonce B, then hold a third `nonce_valid`.
  - `nonce_ready` stays 0 until B loads.
  - Three frames are output in order with no lost or duplicated data.
- Assert `rst` during byte 3 of a nonce frame with a loop request pending.
  - Next cycle: `ser_out`=1, `busy`=0, both readies=1.
  - No further `new_tx_data` pulses.
  - A subsequent loop 0x01 produces a clean `55 01 01 01`.

Source files
------------

// File: rtl/siaminer_resp_tx.sv
`default_nettype none
// ============================================================================
//  Module   : siaminer_resp_tx
//  Purpose  : Response-side 8N1 UART transmitter for the siaminer host link.
//             Frames found-nonce and loop-ack events as 55/cmd/len/payload.
//  Revision : 1.0  initial release
// ============================================================================
module siaminer_resp_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nonce_valid,
    input  logic [31:0] nonce,
    output logic        nonce_ready,
    input  logic        loop_valid,
    input  logic [7:0]  loop_byte,
    output logic        loop_ready,
    output logic        ser_out,
    output logic        busy,
    output logic        new_tx_data,
    output logic        tx_last_byte
);

    localparam int                 c_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_PRE  = c_CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [7:0] c_SYNC      = 8'h55;
    localparam logic [7:0] c_CMD_NONCE = 8'h00;
    localparam logic [7:0] c_CMD_LOOP  = 8'h01;
    localparam logic [7:0] c_LEN_NONCE = 8'h04;
    localparam logic [7:0] c_LEN_LOOP  = 8'h01;
    // Final byte index of a frame is len + 2 (sync, cmd, len precede payload).
    localparam logic [2:0] c_IDX_LAST_NONCE = 3'd6;
    localparam logic [2:0] c_IDX_LAST_LOOP  = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state,      w_state_nxt;
    logic [c_CNT_W-1:0] r_bit_cnt,    w_bit_cnt_nxt;
    logic [2:0]         r_bit_idx,    w_bit_idx_nxt;
    logic [2:0]         r_byte_idx,   w_byte_idx_nxt;
    logic [7:0]         r_shift,      w_shift_nxt;
    logic               r_is_nonce,   w_is_nonce_nxt;
    logic [31:0]        r_frame_data, w_frame_data_nxt;
    logic               r_ser_out,    w_ser_out_nxt;
    logic               r_busy,       w_busy_nxt;
    logic               r_new_tx,     w_new_tx_nxt;
    logic               r_last,       w_last_nxt;
    logic               r_nonce_pend, w_nonce_pend_nxt;
    logic [31:0]        r_nonce_val,  w_nonce_val_nxt;
    logic               r_loop_pend,  w_loop_pend_nxt;
    logic [7:0]         r_loop_val,   w_loop_val_nxt;

    logic [7:0]         w_cur_byte;
    logic               w_last_byte;

    // Select the frame byte addressed by the byte index.
    always_comb begin
        w_cur_byte = r_frame_data[31:24];
        case (r_byte_idx)
            3'd0:    w_cur_byte = c_SYNC;
            3'd1:    w_cur_byte = r_is_nonce ? c_CMD_NONCE : c_CMD_LOOP;
            3'd2:    w_cur_byte = r_is_nonce ? c_LEN_NONCE : c_LEN_LOOP;
            3'd3:    w_cur_byte = r_frame_data[7:0];
            3'd4:    w_cur_byte = r_frame_data[15:8];
            3'd5:    w_cur_byte = r_frame_data[23:16];
            default: w_cur_byte = r_frame_data[31:24];
        endcase
        w_last_byte = (r_byte_idx == (r_is_nonce ? c_IDX_LAST_NONCE : c_IDX_LAST_LOOP));
    end

    // Next-state logic: slot capture, frame load and bit/byte sequencing.
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_bit_idx_nxt    = r_bit_idx;
        w_byte_idx_nxt   = r_byte_idx;
        w_shift_nxt      = r_shift;
        w_is_nonce_nxt   = r_is_nonce;
        w_frame_data_nxt = r_frame_data;
        w_ser_out_nxt    = r_ser_out;
        w_busy_nxt       = r_busy;
        w_new_tx_nxt     = 1'b0;
        w_last_nxt       = 1'b0;
        w_nonce_pend_nxt = r_nonce_pend;
        w_nonce_val_nxt  = r_nonce_val;
        w_loop_pend_nxt  = r_loop_pend;
        w_loop_val_nxt   = r_loop_val;

        // A slot only captures while empty, so capture never collides with
        // the load-time clear below.
        if (nonce_valid && !r_nonce_pend) begin
            w_nonce_pend_nxt = 1'b1;
            w_nonce_val_nxt  = nonce;
        end
        if (loop_valid && !r_loop_pend) begin
            w_loop_pend_nxt = 1'b1;
            w_loop_val_nxt  = loop_byte;
        end

        case (r_state)
            S_IDLE: begin
                w_ser_out_nxt = 1'b1;
                w_busy_nxt    = 1'b0;
                if (r_nonce_pend || r_loop_pend) begin
                    if (r_nonce_pend) begin
                        w_nonce_pend_nxt = 1'b0;
                        w_is_nonce_nxt   = 1'b1;
                        w_frame_data_nxt = r_nonce_val;
                    end else begin
                        w_loop_pend_nxt  = 1'b0;
                        w_is_nonce_nxt   = 1'b0;
                        w_frame_data_nxt = {24'h0, r_loop_val};
                    end
                    w_state_nxt    = S_START;
                    w_ser_out_nxt  = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_bit_cnt_nxt  = '0;
                    w_bit_idx_nxt  = 3'd0;
                    w_byte_idx_nxt = 3'd0;
                end
            end
            S_START: begin
                if (r_bit_cnt == c_BIT_LAST) begin
                    w_bit_cnt_nxt = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_shift_nxt   = w_cur_byte;
                    w_ser_out_nxt = w_cur_byte[0];
                    w_state_nxt   = S_DATA;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                end
            end
            S_DATA: begin
                if (r_bit_cnt == c_BIT_LAST) begin
                    w_bit_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_ser_out_nxt = 1'b1;
                        w_state_nxt   = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_ser_out_nxt = r_shift[1];
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                end
            end
            S_STOP: begin
                // Registered strobe lands on the stop bit's final clock.
                if (r_bit_cnt == c_BIT_PRE) begin
                    w_new_tx_nxt = 1'b1;
                    w_last_nxt   = w_last_byte;
                end
                if (r_bit_cnt == c_BIT_LAST) begin
                    w_bit_cnt_nxt = '0;
                    if (w_last_byte) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + 3'd1;
                        w_ser_out_nxt  = 1'b0;
                        w_state_nxt    = S_START;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset abandons any frame and empties both slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_bit_idx    <= 3'd0;
            r_byte_idx   <= 3'd0;
            r_shift      <= 8'h00;
            r_is_nonce   <= 1'b0;
            r_frame_data <= 32'h0;
            r_ser_out    <= 1'b1;
            r_busy       <= 1'b0;
            r_new_tx     <= 1'b0;
            r_last       <= 1'b0;
            r_nonce_pend <= 1'b0;
            r_nonce_val  <= 32'h0;
            r_loop_pend  <= 1'b0;
            r_loop_val   <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_is_nonce   <= w_is_nonce_nxt;
            r_frame_data <= w_frame_data_nxt;
            r_ser_out    <= w_ser_out_nxt;
            r_busy       <= w_busy_nxt;
            r_new_tx     <= w_new_tx_nxt;
            r_last       <= w_last_nxt;
            r_nonce_pend <= w_nonce_pend_nxt;
            r_nonce_val  <= w_nonce_val_nxt;
            r_loop_pend  <= w_loop_pend_nxt;
            r_loop_val   <= w_loop_val_nxt;
        end
    end

    assign nonce_ready  = !r_nonce_pend;
    assign loop_ready   = !r_loop_pend;
    assign ser_out      = r_ser_out;
    assign busy         = r_busy;
    assign new_tx_data  = r_new_tx;
    assign tx_last_byte = r_last;

endmodule
`default_nettype wire
